// File: rtl/ex_muldiv.sv
// ex_muldiv: MIPS execute stage. Single-cycle ALU and address generation, plus a
// 32-step iterative multiply/divide unit that owns the architectural HI/LO registers.
module ex_muldiv (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  output logic [31:0] Result,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12,
                         FN_MTLO = 6'h13, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] zimm;
  logic        is_rtype, is_muldiv, is_mthi, is_mtlo;
  logic        unused_ins_bits;

  assign opcode          = Ins[31:26];
  assign funct           = Ins[5:0];
  assign shamt           = Ins[10:6];
  assign zimm            = {16'h0, Ins[15:0]};
  assign unused_ins_bits = ^Ins[25:16];
  assign is_rtype        = (opcode == OP_RTYPE);
  // funct 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
  assign is_muldiv       = is_rtype && (funct[5:2] == 4'b0110);
  assign is_mthi         = is_rtype && (funct == FN_MTHI);
  assign is_mtlo         = is_rtype && (funct == FN_MTLO);

  logic [1:0]  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] alu_res;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    alu_res = 32'h0;
    if (is_rtype) begin
      case (funct)
        FN_SLL:          alu_res = Rdata2 << shamt;
        FN_SRL:          alu_res = Rdata2 >> shamt;
        FN_SRA:          alu_res = $signed(Rdata2) >>> shamt;
        FN_MFHI:         alu_res = hi_q;
        FN_MFLO:         alu_res = lo_q;
        FN_ADD, FN_ADDU: alu_res = Rdata1 + Rdata2;
        FN_SUB, FN_SUBU: alu_res = Rdata1 - Rdata2;
        FN_AND:          alu_res = Rdata1 & Rdata2;
        FN_OR:           alu_res = Rdata1 | Rdata2;
        FN_XOR:          alu_res = Rdata1 ^ Rdata2;
        FN_NOR:          alu_res = ~(Rdata1 | Rdata2);
        FN_SLT:          alu_res = {31'h0, $signed(Rdata1) < $signed(Rdata2)};
        FN_SLTU:         alu_res = {31'h0, Rdata1 < Rdata2};
        default:         alu_res = 32'h0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_res = Rdata1 + Ed32;
        OP_SLTI:  alu_res = {31'h0, $signed(Rdata1) < $signed(Ed32)};
        OP_SLTIU: alu_res = {31'h0, Rdata1 < Ed32};
        OP_ANDI:  alu_res = Rdata1 & zimm;
        OP_ORI:   alu_res = Rdata1 | zimm;
        OP_XORI:  alu_res = Rdata1 ^ zimm;
        OP_LUI:   alu_res = {Ins[15:0], 16'h0};
        default:  alu_res = 32'h0;
      endcase
    end
  end

  // acc holds {partial product, multiplier} or {remainder, quotient} during BUSY
  logic [32:0] mul_sum, div_trial, div_diff;
  logic [63:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'h0);
    div_trial = acc_q[63:31];
    div_diff  = div_trial - {1'b0, opb_q};
    if (is_div_q) begin
      step = (div_trial >= {1'b0, opb_q}) ? {div_diff[31:0], acc_q[30:0], 1'b1}
                                          : {div_trial[31:0], acc_q[30:0], 1'b0};
    end else begin
      step = {mul_sum, acc_q[31:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (is_muldiv) begin
          a_neg_d  = ~funct[0] & Rdata1[31];
          b_neg_d  = ~funct[0] & Rdata2[31];
          is_div_d = funct[1];
          acc_d    = {32'h0, a_neg_d ? 32'h0 - Rdata1 : Rdata1};
          opb_d    = b_neg_d ? 32'h0 - Rdata2 : Rdata2;
          count_d  = 6'd32;
          state_d  = ST_BUSY;
        end else if (is_mthi) begin
          hi_d = Rdata1;
        end else if (is_mtlo) begin
          lo_d = Rdata1;
        end
      end
      ST_BUSY: begin
        acc_d   = step;
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) begin
          state_d = ST_DONE;
          if (is_div_q) begin
            // a zero divisor leaves the dividend magnitude in the remainder, so HI = rs falls out
            lo_d = (opb_q == 32'h0) ? 32'hFFFF_FFFF
                 : (a_neg_q ^ b_neg_q) ? 32'h0 - step[31:0] : step[31:0];
            hi_d = a_neg_q ? 32'h0 - step[63:32] : step[63:32];
          end else begin
            {hi_d, lo_d} = (a_neg_q ^ b_neg_q) ? 64'h0 - step : step;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      count_q  <= 6'd0;
      acc_q    <= 64'h0;
      opb_q    <= 32'h0;
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign HI     = hi_q;
  assign LO     = lo_q;
  assign Stall  = RST & (((state_q == ST_IDLE) & is_muldiv) | (state_q == ST_BUSY));
  assign Result = RST ? alu_res : 32'h0;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors with literal expectations, plus a cycle-by-cycle
// comparison against an arithmetic reference model of the execute stage.
module tb_ex_muldiv;
  logic        CLK;
  logic        RST;
  logic [31:0] Ins, Rdata1, Rdata2, Ed32;
  logic [31:0] Result, HI, LO;
  logic        Stall;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32),
    .Result(Result), .Stall(Stall), .HI(HI), .LO(LO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic is_md(input logic [31:0] ins);
    return ins[31:26] == 6'h00 && ins[5:0] >= 6'h18 && ins[5:0] <= 6'h1B;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_alu(input logic [31:0] ins, a, b, ed, hi, lo);
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    int          sa, sb, se;
    logic [31:0] zimm;
    op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
    sa = a; sb = b; se = ed;
    zimm = {16'h0, ins[15:0]};
    if (op == 6'h00) begin
      case (fn)
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return sb >>> sh;
        6'h10: return hi;
        6'h12: return lo;
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: return (a < b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    case (op)
      6'h08, 6'h09, 6'h23, 6'h2B: return a + ed;
      6'h0A: return (sa < se) ? 32'd1 : 32'd0;
      6'h0B: return (a < ed) ? 32'd1 : 32'd0;
      6'h0C: return a & zimm;
      6'h0D: return a | zimm;
      6'h0E: return a ^ zimm;
      6'h0F: return {ins[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  // returns {HI, LO}
  function automatic logic [63:0] model_md(input logic [5:0] fn, input logic [31:0] a, b);
    longint sa, sb;
    int     ia, ib, q, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ia = a; ib = b;
    case (fn)
      6'h18: return 64'(sa * sb);
      6'h19: return {32'h0, a} * {32'h0, b};
      6'h1A: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib; r = ia % ib;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic [63:0] m_pend = 64'h0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        m_hi = 32'h0; m_lo = 32'h0; m_left = 0; m_done = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (is_md(Ins)) begin
        m_pend = model_md(Ins[5:0], Rdata1, Rdata2);
        m_left = 32;
      end else if (Ins == rtype(6'h11, 5'd0) || (Ins[31:26] == 6'h00 && Ins[5:0] == 6'h11)) begin
        m_hi = Rdata1;
      end else if (Ins[31:26] == 6'h00 && Ins[5:0] == 6'h13) begin
        m_lo = Rdata1;
      end
    end
  end

  // compare process: every falling edge
  initial begin
    logic exp_stall;
    forever begin
      @(negedge CLK);
      exp_stall = RST && ((m_left == 0 && !m_done && is_md(Ins)) || m_left > 0);
      check("cmp_result", Result, RST ? model_alu(Ins, Rdata1, Rdata2, Ed32, m_hi, m_lo) : 32'h0);
      check("cmp_stall", {31'h0, Stall}, {31'h0, exp_stall});
      check("cmp_hi", HI, m_hi);
      check("cmp_lo", LO, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [31:0] ins, r1, r2, ed);
    @(posedge CLK);
    #1;
    Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed32 = ed;
    @(negedge CLK);
  endtask

  task automatic apply_i(input logic [5:0] op, input logic [15:0] imm, input logic [31:0] r1);
    apply(itype(op, imm), r1, 32'h0, {{16{imm[15]}}, imm});
  endtask

  // issues a mul/div and counts Stall-high cycles; returns at the falling edge of DONE
  task automatic run_md(input logic [5:0] fn, input logic [31:0] r1, r2, output int n);
    apply(rtype(fn, 5'd0), r1, r2, 32'h0);
    n = 0;
    while (Stall === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int n;
    RST = 1'b0; Ins = 32'h0; Rdata1 = 32'h0; Rdata2 = 32'h0; Ed32 = 32'h0;
    repeat (2) @(negedge CLK);
    check("reset_stall", {31'h0, Stall}, 32'h0);
    check("reset_result", Result, 32'h0);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    #2 RST = 1'b1;

    // ALU sweep
    apply(rtype(6'h21, 5'd0), 32'h7FFF_FFFF, 32'h1, 32'h0);
    check("addu_wrap", Result, 32'h8000_0000);
    apply(rtype(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0);
    check("slt_signed", Result, 32'h1);
    apply(rtype(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0);
    check("sltu_unsigned", Result, 32'h0);
    apply(rtype(6'h03, 5'd4), 32'h0, 32'h8000_0000, 32'h0);
    check("sra", Result, 32'hF800_0000);
    apply(rtype(6'h02, 5'd4), 32'h0, 32'h8000_0000, 32'h0);
    check("srl", Result, 32'h0800_0000);
    apply(rtype(6'h23, 5'd0), 32'h0, 32'h1, 32'h0);
    check("subu_wrap", Result, 32'hFFFF_FFFF);
    apply(rtype(6'h27, 5'd0), 32'h0F0F_0000, 32'h0000_00F0, 32'h0);
    check("nor", Result, 32'hF0F0_FF0F);
    apply_i(6'h0F, 16'h1234, 32'hDEAD_BEEF);
    check("lui", Result, 32'h1234_0000);
    apply_i(6'h23, 16'hFFFC, 32'h0000_0100);
    check("lw_addr", Result, 32'h0000_00FC);
    apply_i(6'h2B, 16'h0008, 32'h0000_1000);
    check("sw_addr", Result, 32'h0000_1008);
    apply_i(6'h0C, 16'h8001, 32'hFFFF_FFFF);
    check("andi_zext", Result, 32'h0000_8001);
    apply_i(6'h0E, 16'hFFFF, 32'h1234_5678);
    check("xori_zext", Result, 32'h1234_A987);
    apply_i(6'h0A, 16'hFFFF, 32'h5);
    check("slti", Result, 32'h0);
    apply_i(6'h0B, 16'hFFFF, 32'h5);
    check("sltiu", Result, 32'h1);
    apply_i(6'h08, 16'hFFFF, 32'h0);
    check("addi_neg", Result, 32'hFFFF_FFFF);
    apply_i(6'h3F, 16'h1234, 32'h5555_5555);
    check("unknown_op", Result, 32'h0);

    // MULT -2 x 3 with stall window and immediate MFLO/MFHI
    run_md(6'h18, 32'hFFFF_FFFE, 32'h3, n);
    check("mult_stall_cycles", 32'(n), 32'd33);
    check("mult_done_stall", {31'h0, Stall}, 32'h0);
    check("mult_done_result", Result, 32'h0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    apply(rtype(6'h12, 5'd0), 32'h0, 32'h0, 32'h0);
    check("mflo_after_mult", Result, 32'hFFFF_FFFA);
    apply(rtype(6'h10, 5'd0), 32'h0, 32'h0, 32'h0);
    check("mfhi_after_mult", Result, 32'hFFFF_FFFF);

    // divides
    run_md(6'h1A, 32'hFFFF_FFF9, 32'h2, n);
    check("div_stall_cycles", 32'(n), 32'd33);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);
    apply(32'h0, 32'h0, 32'h0, 32'h0);
    run_md(6'h1B, 32'd100, 32'h0, n);
    check("divu_zero_lo", LO, 32'hFFFF_FFFF);
    check("divu_zero_hi", HI, 32'd100);
    apply(32'h0, 32'h0, 32'h0, 32'h0);
    run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);
    apply(32'h0, 32'h0, 32'h0, 32'h0);

    // MULTU then back-to-back DIVU issued in the first IDLE cycle after DONE
    run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);
    run_md(6'h1B, 32'd10, 32'd3, n);
    check("b2b_divu_stall_cycles", 32'(n), 32'd33);
    check("b2b_divu_lo", LO, 32'd3);
    check("b2b_divu_hi", HI, 32'd1);

    // asynchronous reset in the middle of a MULT
    apply(rtype(6'h18, 5'd0), 32'd5, 32'd7, 32'h0);
    repeat (10) @(negedge CLK);
    check("busy_stall_before_reset", {31'h0, Stall}, 32'h1);
    #2 RST = 1'b0;
    #1;
    check("async_reset_stall", {31'h0, Stall}, 32'h0);
    check("async_reset_hi", HI, 32'h0);
    check("async_reset_lo", LO, 32'h0);
    Ins = rtype(6'h11, 5'd0); Rdata1 = 32'hAA; Rdata2 = 32'h0;
    @(negedge CLK);
    #2 RST = 1'b1;
    check("post_reset_hi", HI, 32'h0);
    check("post_reset_lo", LO, 32'h0);
    apply(rtype(6'h10, 5'd0), 32'h0, 32'h0, 32'h0);
    check("mthi_mfhi", Result, 32'hAA);
    apply(32'h0, 32'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
